ppfifo_put_arbiter: RTL
=======================

Name: ppfifo_put_arbiter

Overview:
Round-robin arbiter that shares the single WRITER (put) port of the ppfifo between NUM_REQUESTERS producer lanes, e.g. Hamming encoder lanes.
Each lane uses the same put_req/put_value/put_ack handshake as the ppfifo itself, so a lane cannot tell whether it is wired to the arbiter or directly to the FIFO.
The block owns the ppfifo clear line, detects handshake violations and flags ack timeouts.

Parameters:
NUM_REQUESTERS, 4, number of producer lanes (>=2)
FIFO_WORD_SIZE, 1, width of put_value in bits
ACK_TIMEOUT, 16, cycles in BUSY without fifo_put_ack before ack_timeout is set (>=2)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous reset, active low
req_put_req  input  NUM_REQUESTERS  per-lane put request
req_put_value  input  NUM_REQUESTERS*FIFO_WORD_SIZE  lane i data at [i*FIFO_WORD_SIZE +: FIFO_WORD_SIZE]
req_put_ack  output  NUM_REQUESTERS  per-lane acknowledge
clear  input  1  clear command from system control
fifo_clear  output  1  to ppfifo clear
fifo_put_req  output  1  to ppfifo put_req
fifo_put_value  output  FIFO_WORD_SIZE  to ppfifo put_value
fifo_put_ack  input  1  from ppfifo put_ack
grant_valid  output  1  high in BUSY and DRAIN
grant_id  output  max(1,$clog2(NUM_REQUESTERS))  lane currently granted
protocol_error  output  1  sticky: granted lane dropped req before ack
ack_timeout  output  1  sticky: ACK_TIMEOUT expired in BUSY

Behaviour:
- Reset (reset_n low at a rising edge): state=IDLE, fifo_put_req=0, fifo_clear=0, grant_id=0, last_grant=NUM_REQUESTERS-1 so lane 0 wins first, timeout counter=0, protocol_error=0, ack_timeout=0. Reset overrides everything, including mid-transaction: fifo_put_req drops on the same edge.
- fifo_put_req, fifo_clear, grant_id, state, flags: registered.
- fifo_put_value = lane grant_id's slice, combinational mux on registered grant_id. It is driven 0 when grant_valid=0.
- req_put_ack[i] = fifo_put_ack & grant_valid & (grant_id==i), combinational. Ungranted lanes always see 0.
- IDLE:
  - If any req_put_req bit is set, select the first set bit searching last_grant+1, last_grant+2, ... with wrap modulo NUM_REQUESTERS.
  - On that edge: grant_id<=winner, fifo_put_req<=1, counter<=0, go to BUSY.
  - Latency from lane req to fifo_put_req is 1 cycle.
- BUSY:
  - fifo_put_req=1.
  - Set an internal acked bit once fifo_put_ack=1 has been seen.
  - When req_put_req[grant_id]=0: fifo_put_req<=0, go to DRAIN.
  - If the lane drops req while acked=0, also set protocol_error.
  - The counter increments each BUSY cycle while acked=0. When it reaches ACK_TIMEOUT, set ack_timeout and stay in BUSY (no forced release).
- DRAIN:
  - fifo_put_req=0.
  - When fifo_put_ack=0: last_grant<=grant_id, go to IDLE.
  - DRAIN lasts at least 1 cycle, so a lane cannot be re-granted back-to-back while others are waiting.
- Lanes requesting during BUSY or DRAIN are held off (ack=0) until IDLE re-arbitrates.
- Starvation bound: a requesting lane is granted within NUM_REQUESTERS-1 other grants.
- clear:
  - fifo_clear<=clear, i.e. 1-cycle registered pass-through.
  - While clear=1, state is forced to IDLE with fifo_put_req<=0, and any in-flight grant is abandoned with no error flagged.
  - last_grant is unchanged.
  - Arbitration resumes the cycle after clear returns to 0.
- Simultaneous events: reset > clear > FSM. A lane request and clear on the same edge: clear wins, and the request is re-evaluated later.
- Sticky flags clear only on reset.

Test Plan:
- Single lane, N=4, W=8: lane 2 raises req with 0xA5 at edge k, ppfifo acks, lane drops req -> fifo_put_req=1 from edge k+1, fifo_put_value=0xA5, req_put_ack[2] tracks fifo_put_ack, other acks stay 0, no flags.
- All four lanes held requesting continuously for 8 transactions -> grant_id sequence 0,1,2,3,0,1,2,3; each fifo word equals the granted lane's value; DRAIN of >=1 cycle between grants.
- After lane 1 is served, lanes 1 and 3 both request -> lane 3 is granted before lane 1 (round-robin from last_grant+1).
- Lane 0 drops req before any ack -> protocol_error=1 and stays 1; fifo_put_req falls; next lane is granted normally.
- ppfifo never acks, ACK_TIMEOUT=16 -> ack_timeout rises after 16 BUSY cycles and fifo_put_req stays 1; then clear pulse -> fifo_clear high 1 cycle later, state IDLE, fifo_put_req=0.
- reset_n low mid-BUSY -> next edge: fifo_put_req=0, grant_valid=0, flags=0, lane 0 wins the next arbitration.

Source files
------------

// File: rtl/ppfifo_put_arbiter.sv
// Round-robin arbiter sharing the single ppfifo put port between several producer lanes.
// It also owns the ppfifo clear line and flags handshake violations and ack timeouts.
//
// state | meaning
// IDLE  | no grant; arbitrate from last_grant+1 when any lane requests
// BUSY  | fifo_put_req high for the granted lane, waiting for it to drop req
// DRAIN | fifo_put_req low, waiting for the ppfifo to release put_ack
module ppfifo_put_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int FIFO_WORD_SIZE = 1,
  parameter int ACK_TIMEOUT    = 16
) (
  input  logic                                     clock,
  input  logic                                     reset_n,
  input  logic [NUM_REQUESTERS-1:0]                req_put_req,
  input  logic [NUM_REQUESTERS*FIFO_WORD_SIZE-1:0] req_put_value,
  output logic [NUM_REQUESTERS-1:0]                req_put_ack,
  input  logic                                     clear,
  output logic                                     fifo_clear,
  output logic                                     fifo_put_req,
  output logic [FIFO_WORD_SIZE-1:0]                fifo_put_value,
  input  logic                                     fifo_put_ack,
  output logic                                     grant_valid,
  output logic [((NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1)-1:0] grant_id,
  output logic                                     protocol_error,
  output logic                                     ack_timeout
);

  localparam int GW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t        state;
  logic [GW-1:0] last_grant;
  logic [CW-1:0] cnt;
  logic          acked;
  logic          win_found;
  logic [GW-1:0] win_id;

  assign grant_valid = (state != IDLE);

  // Scan offsets from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = NUM_REQUESTERS; k >= 1; k--) begin
      int            idx;
      logic [GW-1:0] idx_g;
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQUESTERS) idx = idx - NUM_REQUESTERS;
      idx_g = GW'(idx);
      if (req_put_req[idx_g]) begin
        win_found = 1'b1;
        win_id    = idx_g;
      end
    end
  end

  always_comb begin
    fifo_put_value = '0;
    req_put_ack    = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant_valid && (grant_id == GW'(i))) begin
        fifo_put_value = req_put_value[i*FIFO_WORD_SIZE +: FIFO_WORD_SIZE];
        req_put_ack[i] = fifo_put_ack;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= IDLE;
      fifo_put_req   <= 1'b0;
      fifo_clear     <= 1'b0;
      grant_id       <= '0;
      last_grant     <= GW'(NUM_REQUESTERS - 1);
      cnt            <= '0;
      acked          <= 1'b0;
      protocol_error <= 1'b0;
      ack_timeout    <= 1'b0;
    end else begin
      fifo_clear <= clear;
      if (clear) begin
        state        <= IDLE;
        fifo_put_req <= 1'b0;
        acked        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (win_found) begin
              grant_id     <= win_id;
              fifo_put_req <= 1'b1;
              cnt          <= '0;
              acked        <= 1'b0;
              state        <= BUSY;
            end
          end
          BUSY: begin
            if (fifo_put_ack) acked <= 1'b1;
            if (!acked && !fifo_put_ack && !ack_timeout) begin
              cnt <= cnt + 1'b1;
              if (cnt == CW'(ACK_TIMEOUT - 1)) ack_timeout <= 1'b1;
            end
            if (!req_put_req[grant_id]) begin
              fifo_put_req <= 1'b0;
              state        <= DRAIN;
              if (!acked && !fifo_put_ack) protocol_error <= 1'b1;
            end
          end
          DRAIN: begin
            if (!fifo_put_ack) begin
              last_grant <= grant_id;
              state      <= IDLE;
            end
          end
          default: begin
            state        <= IDLE;
            fifo_put_req <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
